// File: rtl/z3_slave_engine.sv
// rtl/z3_slave_engine.sv - Zorro III slave-cycle engine: strobe sync, region decode, ack handshake, DTACK/data enable.
// Optional watchdog enabled by defining Z3_SLAVE_WDOG_EN.
module z3_slave_engine #(
  parameter int NUM_REGIONS = 4,
  parameter logic [24*NUM_REGIONS-1:0] REGION_BASE = {24'h8C0000, 24'h880000, 24'h800000, 24'h000000},
  parameter logic [24*NUM_REGIONS-1:0] REGION_MASK = {24'hFC0000, 24'hFC0000, 24'hF80000, 24'h800000},
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   CLK_50M,
  input  logic                   IORST_n,
  input  logic                   FCS_n,
  input  logic [3:0]             DS_n,
  input  logic                   READ,
  input  logic [2:0]             FC,
  input  logic [31:0]            A,
  input  logic                   configured,
  input  logic [3:0]             base_addr,
  input  logic [NUM_REGIONS-1:0] region_ack,
  output logic [NUM_REGIONS-1:0] region_sel,
  output logic [23:0]            addr_q,
  output logic                   cycle_act,
  output logic                   dtack,
  output logic                   doe,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] fcs_n_sync;
  logic [SYNC_STAGES-1:0] ds_n_sync;
  logic                   fcs, fcs_q, fcs_rise, ds_any;

  logic [NUM_REGIONS-1:0] sel;
  logic                   hit_any, claim, ack_hit, wd_exp;

  logic [NUM_REGIONS-1:0] region_sel_d;
  logic [23:0]            addr_d;
  logic                   cycle_act_d, dtack_d, doe_d;

  logic unused_ok;
  assign unused_ok = ^{A[27:24], FC[2]};

  // Synchronisers hold the raw active-low level, so preset means "deasserted"
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_n_sync <= '1;
      ds_n_sync  <= '1;
      fcs_q      <= 1'b0;
    end else begin
      fcs_n_sync <= {fcs_n_sync[SYNC_STAGES-2:0], FCS_n};
      ds_n_sync  <= {ds_n_sync[SYNC_STAGES-2:0], &DS_n};
      fcs_q      <= fcs;
    end
  end

  assign fcs      = ~fcs_n_sync[SYNC_STAGES-1];
  assign ds_any   = ~ds_n_sync[SYNC_STAGES-1];
  assign fcs_rise = fcs & ~fcs_q;

  // Descending scan so the lowest matching index is the last one written
  always_comb begin
    hit_any = 1'b0;
    sel     = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((A[23:0] & REGION_MASK[24*i +: 24]) == REGION_BASE[24*i +: 24]) begin
        hit_any = 1'b1;
        sel     = '0;
        sel[i]  = 1'b1;
      end
    end
  end

  assign claim   = fcs_rise & configured & (A[31:28] == base_addr) & (FC[1] ^ FC[0]) & hit_any;
  assign ack_hit = |(region_ack & region_sel);

`ifdef Z3_SLAVE_WDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] wd_cnt, wd_cnt_d;
  logic       timeout_err_q, timeout_err_d;

  assign wd_exp      = (wd_cnt == WD_LIMIT);
  assign timeout_err = timeout_err_q;

  always_comb begin
    wd_cnt_d      = wd_cnt;
    timeout_err_d = timeout_err_q;
    if (state == S_IDLE && claim)
      timeout_err_d = 1'b0;
    if (state == S_ADDR && fcs && (READ || ds_any))
      wd_cnt_d = 8'd0;
    if (state == S_DATA && fcs && !ack_hit) begin
      if (wd_exp)
        timeout_err_d = 1'b1;
      else if (wd_cnt != 8'hFF)
        wd_cnt_d = wd_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      wd_cnt        <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt        <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign wd_exp      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      state      <= S_IDLE;
      region_sel <= '0;
      addr_q     <= 24'd0;
      cycle_act  <= 1'b0;
      dtack      <= 1'b0;
      doe        <= 1'b0;
    end else begin
      state      <= state_d;
      region_sel <= region_sel_d;
      addr_q     <= addr_d;
      cycle_act  <= cycle_act_d;
      dtack      <= dtack_d;
      doe        <= doe_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (claim) state_d = S_ADDR;
      S_ADDR: begin
        if (!fcs)                 state_d = S_IDLE;
        else if (READ || ds_any)  state_d = S_DATA;
      end
      S_DATA: begin
        if (!fcs)                 state_d = S_IDLE;
        else if (ack_hit || wd_exp) state_d = S_END;
      end
      S_END:  if (!fcs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Leaving for IDLE drops every cycle output on the same edge; addr_q keeps the last address
  always_comb begin
    region_sel_d = region_sel;
    addr_d       = addr_q;
    cycle_act_d  = cycle_act;
    dtack_d      = dtack;
    doe_d        = doe;
    case (state)
      S_IDLE: begin
        if (claim) begin
          addr_d       = A[23:0];
          region_sel_d = sel;
          cycle_act_d  = 1'b1;
        end
      end
      S_ADDR, S_DATA, S_END: begin
        if (!fcs) begin
          region_sel_d = '0;
          cycle_act_d  = 1'b0;
          doe_d        = 1'b0;
          dtack_d      = 1'b0;
        end else if (state == S_ADDR && (READ || ds_any)) begin
          doe_d = READ;
        end else if (state == S_END) begin
          dtack_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
